// File: rtl/captura_conmutador.sv
// Switch/button front end: 2-flop synchronisers, per-input debouncers and a
// press-triggered capture register that feeds the Hamming/syndrome stage.

module captura_conmutador_debounce #(
  parameter int W          = 1,
  parameter int N_DEBOUNCE = 270000,
  parameter int CNT_W      = $clog2(N_DEBOUNCE + 1)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] sync,
  output logic [W-1:0] estable,
  output logic [W-1:0] estable_nxt
);

  typedef enum logic {
    ESTABLE   = 1'b0,
    VALIDANDO = 1'b1
  } estado_t;

  localparam logic [CNT_W-1:0] N_C   = CNT_W'(N_DEBOUNCE);
  localparam logic [CNT_W-1:0] UNO_C = CNT_W'(1);

  estado_t          estado_q, estado_n;
  logic [W-1:0]     cand_q, cand_n;
  logic [W-1:0]     est_q, est_n;
  logic [CNT_W-1:0] cnt_q, cnt_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado_q <= ESTABLE;
      cand_q   <= '0;
      est_q    <= '0;
      cnt_q    <= '0;
    end else begin
      estado_q <= estado_n;
      cand_q   <= cand_n;
      est_q    <= est_n;
      cnt_q    <= cnt_n;
    end
  end

  // The whole vector is compared, so any bit moving mid-window restarts the count.
  always_comb begin
    estado_n = estado_q;
    cand_n   = cand_q;
    est_n    = est_q;
    cnt_n    = cnt_q;
    case (estado_q)
      ESTABLE: begin
        if (sync != est_q) begin
          estado_n = VALIDANDO;
          cand_n   = sync;
          cnt_n    = UNO_C;
        end else begin
          cnt_n = '0;
        end
      end
      VALIDANDO: begin
        if (sync == est_q) begin
          estado_n = ESTABLE;
          cnt_n    = '0;
        end else if (sync != cand_q) begin
          cand_n = sync;
          cnt_n  = UNO_C;
        end else if (cnt_q == N_C) begin
          est_n    = cand_q;
          estado_n = ESTABLE;
          cnt_n    = '0;
        end else begin
          cnt_n = cnt_q + UNO_C;
        end
      end
      default: begin
        estado_n = ESTABLE;
        cnt_n    = '0;
      end
    endcase
  end

  assign estable     = est_q;
  assign estable_nxt = est_n;

endmodule

module captura_conmutador #(
  parameter int N_DEBOUNCE = 270000,
  parameter int CNT_W      = $clog2(N_DEBOUNCE + 1)
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] sw_in,
  input  logic       boton_in,
  output logic [3:0] palabra_estable,
  output logic       cambio_palabra,
  output logic [3:0] conmutador_4,
  output logic       captura_valida
);

  logic [3:0] sw_m, sw_s;
  logic       bt_m, bt_s;
  logic [3:0] pal_q, pal_nxt;
  logic [0:0] bt_est, bt_nxt;
  logic       cambio_n, captura_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sw_m <= '0;
      sw_s <= '0;
      bt_m <= 1'b0;
      bt_s <= 1'b0;
    end else begin
      sw_m <= sw_in;
      sw_s <= sw_m;
      bt_m <= boton_in;
      bt_s <= bt_m;
    end
  end

  captura_conmutador_debounce #(
    .W(4), .N_DEBOUNCE(N_DEBOUNCE), .CNT_W(CNT_W)
  ) u_deb_palabra (
    .clk(clk), .rst_n(rst_n), .sync(sw_s),
    .estable(pal_q), .estable_nxt(pal_nxt)
  );

  captura_conmutador_debounce #(
    .W(1), .N_DEBOUNCE(N_DEBOUNCE), .CNT_W(CNT_W)
  ) u_deb_boton (
    .clk(clk), .rst_n(rst_n), .sync(bt_s),
    .estable(bt_est), .estable_nxt(bt_nxt)
  );

  // Capture takes the word's next value so a simultaneous update is not missed.
  assign cambio_n  = (pal_nxt != pal_q);
  assign captura_n = ~bt_est[0] & bt_nxt[0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cambio_palabra <= 1'b0;
      captura_valida <= 1'b0;
      conmutador_4   <= '0;
    end else begin
      cambio_palabra <= cambio_n;
      captura_valida <= captura_n;
      if (captura_n) conmutador_4 <= pal_nxt;
    end
  end

  assign palabra_estable = pal_q;

endmodule

// File: tb/tb_captura_conmutador.sv
// Bench for captura_conmutador with N_DEBOUNCE=4: table of word/capture steps
// plus hand sequences for glitches, bounces, simultaneous update and reset.

module tb_captura_conmutador;

  localparam int N = 4;
  localparam int LAT = 2 + N + 1;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] sw_in = 4'b0000;
  logic       boton_in = 1'b0;
  logic [3:0] palabra_estable;
  logic       cambio_palabra;
  logic [3:0] conmutador_4;
  logic       captura_valida;

  int total = 0;
  int bad = 0;
  logic [3:0] exp_q[$];

  captura_conmutador #(.N_DEBOUNCE(N)) dut (
    .clk(clk), .rst_n(rst_n), .sw_in(sw_in), .boton_in(boton_in),
    .palabra_estable(palabra_estable), .cambio_palabra(cambio_palabra),
    .conmutador_4(conmutador_4), .captura_valida(captura_valida)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] sw;
    logic       press;
    logic [3:0] exp_pal;
    logic [3:0] exp_conm;
  } vec_t;

  vec_t vecs[4];

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Returns the cycle (1..30) on which the chosen pulse was seen, 0 on timeout.
  task automatic wait_pulse(input bit sel_cap, output int k);
    k = 0;
    for (int i = 1; i <= 30; i++) begin
      @(posedge clk);
      #1;
      if ((sel_cap ? captura_valida : cambio_palabra) === 1'b1) begin
        k = i;
        break;
      end
    end
  endtask

  task automatic quiet(input string name, input int n);
    int pulses;
    pulses = 0;
    for (int i = 0; i < n; i++) begin
      tick(1);
      if (cambio_palabra || captura_valida) pulses++;
    end
    check(name, pulses, 0);
  endtask

  // Scoreboard / pulse-width monitor, sampled away from the active edge.
  logic prev_cambio = 1'b0, prev_cap = 1'b0;
  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (captura_valida === 1'b1) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_capture: got conmutador_4=%b with no expected word", conmutador_4);
        end else begin
          check("capture_word", int'(conmutador_4), int'(exp_q.pop_front()));
        end
        check("captura_width", int'(prev_cap), 0);
      end
      if (cambio_palabra === 1'b1) check("cambio_width", int'(prev_cambio), 0);
      prev_cap    = captura_valida;
      prev_cambio = cambio_palabra;
    end
  end

  initial begin
    int k;
    vecs[0] = '{sw: 4'b1011, press: 1'b0, exp_pal: 4'b1011, exp_conm: 4'b0000};
    vecs[1] = '{sw: 4'b0110, press: 1'b1, exp_pal: 4'b0110, exp_conm: 4'b0110};
    vecs[2] = '{sw: 4'b1111, press: 1'b0, exp_pal: 4'b1111, exp_conm: 4'b0110};
    vecs[3] = '{sw: 4'b1111, press: 1'b1, exp_pal: 4'b1111, exp_conm: 4'b1111};

    #1;
    check("reset_pal", int'(palabra_estable), 0);
    check("reset_cambio", int'(cambio_palabra), 0);
    check("reset_conm", int'(conmutador_4), 0);
    check("reset_cap", int'(captura_valida), 0);
    tick(3);
    rst_n = 1'b1;
    tick(3);

    // Glitching word: 0101/0000 every 2 cycles never survives the window.
    for (int i = 0; i < 10; i++) begin
      sw_in = (i % 2 == 0) ? 4'b0101 : 4'b0000;
      for (int j = 0; j < 2; j++) begin
        tick(1);
        if (cambio_palabra || palabra_estable != 4'b0000)
          check("glitch_pal", int'(palabra_estable), 0);
      end
    end
    sw_in = 4'b0000;
    quiet("glitch_quiet", 10);
    check("glitch_final", int'(palabra_estable), 0);

    // Short button bounce: 3 cycles is below the window.
    boton_in = 1'b1;
    tick(3);
    boton_in = 1'b0;
    quiet("bounce_quiet", 12);
    check("bounce_conm", int'(conmutador_4), 0);

    for (int v = 0; v < 4; v++) begin
      if (vecs[v].sw != palabra_estable) begin
        sw_in = vecs[v].sw;
        wait_pulse(1'b0, k);
        check($sformatf("v%0d_word_lat", v), k, LAT);
        check($sformatf("v%0d_pal", v), int'(palabra_estable), int'(vecs[v].exp_pal));
        quiet($sformatf("v%0d_word_quiet", v), 4);
      end
      if (vecs[v].press) begin
        exp_q.push_back(vecs[v].exp_conm);
        boton_in = 1'b1;
        wait_pulse(1'b1, k);
        check($sformatf("v%0d_cap_lat", v), k, LAT);
        quiet($sformatf("v%0d_held", v), 10 - LAT);
        boton_in = 1'b0;
        quiet($sformatf("v%0d_release", v), 12);
      end
      check($sformatf("v%0d_conm", v), int'(conmutador_4), int'(vecs[v].exp_conm));
    end

    // Word and button settle on the same edge: capture takes the new word.
    exp_q.push_back(4'b1001);
    sw_in = 4'b1001;
    boton_in = 1'b1;
    wait_pulse(1'b1, k);
    check("simul_cap_lat", k, LAT);
    check("simul_cambio", int'(cambio_palabra), 1);
    check("simul_conm", int'(conmutador_4), 9);
    quiet("simul_held", 6);
    boton_in = 1'b0;
    quiet("simul_release", 12);

    // Reset at cnt=2 discards the candidate; a full window follows release.
    sw_in = 4'b0011;
    tick(4);
    rst_n = 1'b0;
    #1;
    check("rst_mid_pal", int'(palabra_estable), 0);
    check("rst_mid_conm", int'(conmutador_4), 0);
    check("rst_mid_cambio", int'(cambio_palabra), 0);
    tick(3);
    rst_n = 1'b1;
    wait_pulse(1'b0, k);
    check("rst_rel_lat", k, LAT);
    check("rst_rel_pal", int'(palabra_estable), 3);
    check("rst_rel_conm", int'(conmutador_4), 0);
    quiet("end_quiet", 10);

    check("queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/captura_conmutador.md
Name: captura_conmutador

Overview:
- Front-end stage for the 4-bit data switches and the capture pushbutton.
- Synchronises and debounces both inputs, then latches the debounced word on each debounced button press.
- Presents the captured word as conmutador_4, with a one-cycle strobe, to the Hamming/syndrome stage directly downstream.
- Keeps that stage's input stable between user captures.

Parameters:
- N_DEBOUNCE, default 270000: consecutive stable cycles required to accept a new input level. This is 10 ms at 27 MHz. Legal range is N_DEBOUNCE >= 1; benches use 4.
- CNT_W, default $clog2(N_DEBOUNCE+1): debounce counter width. It is derived, not overridden.

Ports:
- clk, input, 1: system clock.
- rst_n, input, 1: asynchronous active-low reset.
- sw_in, input, 4: raw asynchronous switch levels. Bit 0 maps to w0.
- boton_in, input, 1: raw asynchronous capture button. Pressed = 1.
- palabra_estable, output, 4: current debounced switch word.
- cambio_palabra, output, 1: one-cycle pulse when palabra_estable changes.
- conmutador_4, output, 4: captured word fed to the syndrome stage.
- captura_valida, output, 1: one-cycle pulse when conmutador_4 is loaded.

Behaviour:
- Clocking and reset: one clock, clk. Reset is rst_n, asynchronous and active-low; it asserts immediately and deasserts on the clk edge. All state is reset.
- Reset values:
  - palabra_estable = 0, cambio_palabra = 0, conmutador_4 = 0, captura_valida = 0.
  - Synchronisers = 0, counters = 0, both FSMs in ESTABLE.
- Synchronisation: sw_in[3:0] and boton_in each pass through a 2-flop synchroniser. The synchronised values are sw_s and bt_s.
- Debouncers: two independent instances of the same FSM. One is 4 bits wide (word, on sw_s); one is 1 bit wide (button, on bt_s).
- Each debouncer holds an estable register, a candidato register and a counter cnt.
- State ESTABLE:
  - If sync == estable: stay, cnt = 0.
  - Else: go to VALIDANDO, candidato <= sync, cnt <= 1.
- State VALIDANDO:
  - If sync == estable: glitch rejected; go to ESTABLE, cnt <= 0, no output change.
  - Else if sync != candidato: restart; candidato <= sync, cnt <= 1.
  - Else if cnt == N_DEBOUNCE: estable <= candidato, go to ESTABLE, cnt <= 0. For the word instance, cambio_palabra = 1 for that cycle.
  - Else: cnt <= cnt + 1.
- Word latency: pin change to palabra_estable update is 2 sync cycles + N_DEBOUNCE + 1 cycles, provided the input is held constant.
- Partial changes: the whole 4-bit vector is compared. Any differing bit during validation restarts the count, so partial multi-switch moves settle as one update.
- Capture on press:
  - On the cycle the button debouncer's estable goes 0->1, conmutador_4 <= the value palabra_estable holds after that same edge (new value if both update together).
  - captura_valida is high for exactly that one cycle, registered with conmutador_4.
- Other button behaviour:
  - Button release (1->0) produces no capture.
  - A held button produces exactly one capture.
  - Bounces shorter than N_DEBOUNCE produce none.
- conmutador_4 hold: conmutador_4 holds its value indefinitely between captures. Switch changes alone never alter it.
- Pulse rule: cambio_palabra and captura_valida are never high for more than 1 consecutive cycle.
- Reset mid-validation: any pending candidate is discarded. After release, a still-changed input requires a full new 2 + N_DEBOUNCE + 1 window.
- Counter range: cnt never exceeds N_DEBOUNCE and never wraps.

Test Plan (N_DEBOUNCE=4):
- Reset, then sw_in=4'b1011 held: palabra_estable=1011 on cycle 7 after the change, cambio_palabra pulses once, conmutador_4 stays 0000 and captura_valida stays 0.
- sw_in 0000->0101 toggling back to 0000 every 2 cycles for 20 cycles: palabra_estable stays 0000 and no pulses.
- palabra_estable=0110, then boton_in pulsed high for 3 cycles: no capture. Then held for 10 cycles: conmutador_4=0110 and captura_valida=1 for exactly one cycle, 7 cycles after the rise, with no second pulse while held.
- Button held and released, then sw_in=1111 settles without a press: conmutador_4 keeps the old value. A second press gives conmutador_4=1111.
- sw_in=1001 and boton_in asserted on the same cycle, both held: both debouncers complete on the same edge, conmutador_4=1001, and captura_valida coincides with cambio_palabra.
- sw_in changes, rst_n pulsed low at cnt=2 then released with the input held: outputs are 0 during reset, and palabra_estable updates only 7 cycles after release.
